// File: rtl/rate_sequencer.sv
// Run/pause rate sequencer: divides the clock by LOAD[rate_sel]+1, pulses tick each period and
// advances a 4-bit display digit. Define RATE_LATCH_EN to defer rate changes in RUN to the next reload.
module rate_sequencer #(
    parameter int CNT_W = 27,
    parameter int LOAD0 = 1,
    parameter int LOAD1 = 99999999,
    parameter int LOAD2 = 49999999,
    parameter int LOAD3 = 24999999
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rate_sel,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       clear,
    output logic       tick,
    output logic [3:0] digit,
    output logic       carry,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] load_sel;
    logic             rate_chg;
    logic             reload_now;
    logic             wrap;

    // NOTE: load_sel is assigned on every path of the case, so no latch can be inferred.
    always_comb begin
        load_sel = CNT_W'(LOAD0);
        case (rate_sel)
            2'b00:   load_sel = CNT_W'(LOAD0);
            2'b01:   load_sel = CNT_W'(LOAD1);
            2'b10:   load_sel = CNT_W'(LOAD2);
            default: load_sel = CNT_W'(LOAD3);
        endcase
    end

    assign rate_chg = (rate_sel != sel_q);
    assign wrap     = (digit == 4'hF);

`ifdef RATE_LATCH_EN
    // In RUN the new load value is picked up by the terminal-count reload instead.
    assign reload_now = rate_chg && (state != RUN);
`else
    assign reload_now = rate_chg;
`endif

    // NOTE: non-blocking assignments so every branch below reads pre-edge register values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            div     <= load_sel;
            digit   <= 4'h0;
            tick    <= 1'b0;
            carry   <= 1'b0;
            running <= 1'b0;
            sel_q   <= rate_sel;
        end else begin
            sel_q <= rate_sel;
            tick  <= 1'b0;
            carry <= 1'b0;
            if (clear) begin
                digit <= 4'h0;
                div   <= load_sel;
            end else if (stop) begin
                // div is held so a later start resumes mid-period.
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            end else if (reload_now) begin
                div <= load_sel;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                            div     <= load_sel;
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else if (step) begin
                            tick  <= 1'b1;
                            digit <= digit + 4'd1;
                            carry <= wrap;
                        end
                    end
                    RUN: begin
                        if (div == '0) begin
                            div   <= load_sel;
                            tick  <= 1'b1;
                            digit <= digit + 4'd1;
                            carry <= wrap;
                        end else begin
                            div <= div - 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rate_sequencer.sv
// Directed bench for rate_sequencer with small load values (1, 9, 4, 2); follows RATE_LATCH_EN
// when that macro is defined for the build.
module tb_rate_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] rate_sel;
    logic       start, stop, step, clear;
    logic       tick;
    logic [3:0] digit;
    logic       carry;
    logic       running;

    int n_vec = 0;
    int n_bad = 0;
    int n;
    int nt;

    rate_sequencer #(
        .CNT_W(27), .LOAD0(1), .LOAD1(9), .LOAD2(4), .LOAD3(2)
    ) dut (
        .clock(clock), .reset(reset), .rate_sel(rate_sel),
        .start(start), .stop(stop), .step(step), .clear(clear),
        .tick(tick), .digit(digit), .carry(carry), .running(running)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clock);
        #1;
    endtask

    // Cycles from the current edge until tick is seen, or -1 if the budget runs out.
    task automatic wait_tick(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            step_clk();
            if (tick) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rate_sel = 2'b10;
        start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0;
        step_clk();
        step_clk();
        check("rst_tick", tick, 0);
        check("rst_digit", digit, 0);
        check("rst_carry", carry, 0);
        check("rst_running", running, 0);

        // Rate 10 (load 4): ticks 5, 10, 15 cycles after the start edge.
        reset = 1'b0; start = 1'b1;
        step_clk();
        start = 1'b0;
        check("run_running", running, 1);
        check("run_tick0", tick, 0);
        for (int k = 1; k <= 15; k++) begin
            step_clk();
            check("r10_tick", tick, (k % 5 == 0));
            if (k % 5 == 0) check("r10_digit", digit, k / 5);
        end

        // Clear together with rate 00: 32 ticks, every 2 cycles, carry on wrap only.
        rate_sel = 2'b00; clear = 1'b1;
        step_clk();
        clear = 1'b0;
        check("clr_digit", digit, 0);
        check("clr_tick", tick, 0);
        for (int j = 1; j <= 64; j++) begin
            step_clk();
            check("r00_tick", tick, (j % 2 == 0));
            if (j % 2 == 0) begin
                check("r00_digit", digit, (j / 2) % 16);
                check("r00_carry", carry, ((j / 2) % 16 == 0));
            end else begin
                check("r00_carry0", carry, 0);
            end
        end
        check("r00_final_digit", digit, 0);

        // Rate 01 (load 9): reload on change, stop with div=5.
        rate_sel = 2'b01;
        step_clk();
        check("chg_notick", tick, 0);
        nt = 0;
        repeat (4) begin step_clk(); nt += tick; end
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        check("pause_running", running, 0);
        nt = 0;
        repeat (20) begin step_clk(); nt += tick; end
        check("pause_noticks", nt, 0);

        // Three step ticks in PAUSE.
        for (int s = 1; s <= 3; s++) begin
            step = 1'b1;
            step_clk();
            step = 1'b0;
            check("step_tick", tick, 1);
            check("step_digit", digit, s);
            step_clk();
            check("step_tick_off", tick, 0);
        end

        // Resume: held div=5 gives a tick 6 cycles later.
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("resume_running", running, 1);
        wait_tick(20, n);
        check("resume_latency", n, 6);
        check("resume_digit", digit, 4);

        // Change 01 -> 11 on the edge where div would go 4 -> 3.
        repeat (5) step_clk();
        rate_sel = 2'b11;
        step_clk();
        check("rchg_notick", tick, 0);
        wait_tick(20, n);
`ifdef RATE_LATCH_EN
        check("rchg_latency", n, 4);
`else
        check("rchg_latency", n, 3);
`endif
        check("rchg_digit", digit, 5);
        wait_tick(20, n);
        check("r11_period", n, 3);
        check("r11_digit", digit, 6);

        // start+stop together in PAUSE keeps PAUSE.
        stop = 1'b1;
        step_clk();
        check("stop2_running", running, 0);
        start = 1'b1;
        step_clk();
        start = 1'b0; stop = 1'b0;
        check("startstop_running", running, 0);
        nt = 0;
        repeat (6) begin step_clk(); nt += tick; end
        check("startstop_noticks", nt, 0);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        wait_tick(20, n);
        check("resume2_latency", n, 3);
        check("resume2_digit", digit, 7);

        // Clear in RUN at digit 7: full period before next tick.
        clear = 1'b1;
        step_clk();
        clear = 1'b0;
        check("clr7_digit", digit, 0);
        check("clr7_tick", tick, 0);
        check("clr7_running", running, 1);
        wait_tick(20, n);
        check("clr7_latency", n, 3);
        check("clr7_digit1", digit, 1);

        // Reset with div=1: no tick, reset values.
        step_clk();
        check("predreset_tick", tick, 0);
        reset = 1'b1;
        step_clk();
        check("mrst_tick", tick, 0);
        check("mrst_digit", digit, 0);
        check("mrst_carry", carry, 0);
        check("mrst_running", running, 0);
        step_clk();
        check("mrst_tick2", tick, 0);
        reset = 1'b0;

        // IDLE ignores step and stop.
        step = 1'b1; stop = 1'b1;
        step_clk();
        step = 1'b0; stop = 1'b0;
        nt = 0;
        repeat (10) begin step_clk(); nt += tick; end
        check("idle_noticks", nt, 0);
        check("idle_running", running, 0);
        check("idle_digit", digit, 0);

        start = 1'b1;
        step_clk();
        start = 1'b0;
        wait_tick(20, n);
        check("idle_start_latency", n, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rate_sequencer.md
Name: rate_sequencer

Overview:
- Run/pause controller for the board's rate divider.
- Picks one of four divider load values from a 2-bit rate select and counts it down.
- Emits a one-cycle enable pulse each period and advances a 4-bit display digit (0–F) on every pulse.
- Sits between the switch/key inputs and the hex-display decoder; downstream logic clocks only on `tick`.

Parameters:
- CNT_W, 27, divider counter width.
- LOAD0, 1, load value for rate_sel=00 (period 2 cycles).
- LOAD1, 99999999, load value for rate_sel=01 (0.5 Hz at 50 MHz).
- LOAD2, 49999999, load value for rate_sel=10 (1 Hz).
- LOAD3, 24999999, load value for rate_sel=11 (2 Hz).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rate_sel  in  2  selects LOAD0..LOAD3.
- start  in  1  command: enter RUN.
- stop  in  1  command: enter PAUSE.
- step  in  1  command: single tick while paused.
- clear  in  1  command: zero the digit and reload the divider.
- tick  out  1  one-cycle enable pulse, registered.
- digit  out  4  display counter value.
- carry  out  1  one-cycle pulse when digit wraps F->0, registered.
- running  out  1  high in RUN.

Behaviour:
- Reset values: state=IDLE, div=LOAD[rate_sel], digit=0, tick=0, carry=0, running=0, sel_q=rate_sel.
- Command inputs are sampled every cycle as levels; there is no edge detection.
- States and transitions:
  - IDLE: start -> RUN with div<=LOAD[rate_sel]. step, stop: no effect.
  - RUN: stop -> PAUSE with div held. start: no effect.
  - PAUSE: start -> RUN with div continuing from the held value. step -> stays PAUSE, issues a step tick.
- Per-cycle priority: reset > clear > stop > rate change > step/start > normal count.
- RUN counting:
  - If div==0: div<=LOAD[rate_sel], tick<=1, digit<=digit+1.
  - Else: div<=div-1, tick<=0.
  - First tick appears LOAD+1 cycles after the edge that sampled start, then repeats every LOAD+1 cycles.
- Step tick: tick<=1, digit<=digit+1, div unchanged.
- Digit arithmetic: 4-bit, wraps F->0. carry<=1 in the same cycle tick<=1 and digit goes F->0; carry=0 otherwise.
- sel_q: registers rate_sel every cycle.
- Rate change (default build): in RUN, if rate_sel!=sel_q, then div<=LOAD[rate_sel] and tick<=0. This overrides a coincident terminal count, so no tick is issued that cycle.
  - In IDLE/PAUSE, a rate change reloads div with no tick.
- clear: digit<=0, div<=LOAD[rate_sel], tick<=0, carry<=0; state unchanged.
- stop with start in the same cycle: stop wins, state=PAUSE (from IDLE: stays IDLE).
- tick, carry: 0 in every cycle not explicitly assigned 1.
- running: registered, equals (state==RUN).
- Reset mid-period: all outputs return to reset values on the next edge; no tick emitted.

Optional Feature:
- Macro: RATE_LATCH_EN.
- Defined: a rate_sel change in RUN does not reload div. The new LOAD[rate_sel] is applied only at the next terminal reload, so the current period completes at the old rate and the tick is not suppressed. Rate changes in IDLE/PAUSE still reload immediately.
- Undefined: immediate-reload behaviour as specified above.

Test Plan:
- Bench parameters: LOAD0=1, LOAD1=9, LOAD2=4, LOAD3=2.
- Reset, rate_sel=10, start pulse at cycle 0 -> tick high at cycles 5, 10, 15; digit 1, 2, 3; running=1 from cycle 1.
- RUN with rate_sel=00 for 32 ticks -> tick every 2 cycles; digit goes F->0 on tick 16 with carry=1 that cycle only; digit=0 after tick 32.
- rate_sel=01 in RUN, stop after 4 cycles (div=5), wait 20 cycles, start -> no tick while paused; next tick 6 cycles after the resume edge.
- In PAUSE, pulse step 3 times, 2 cycles apart -> 3 single-cycle ticks, digit +3, div unchanged.
- rate_sel=01 in RUN, change to 11 when div=3 -> no tick; next tick 3 cycles after the change edge. With RATE_LATCH_EN -> tick 4 cycles after the change, following ticks every 3 cycles.
- start and stop asserted together in PAUSE -> stays PAUSE. clear asserted during RUN at digit=7 -> digit=0, full period before the next tick. reset asserted at div=1 -> no tick, all outputs at reset values.
